// File: rtl/mem_store_unit_if.sv
// Store request and RAM write port bundle for mem_store_unit.
// master drives requests and acks; slave is the store unit itself.
interface mem_store_unit_if;
  logic        store_valid_in;
  logic        store_ready_out;
  logic [31:0] store_addr_in;
  logic [31:0] store_data_in;
  logic [3:0]  mem_sel_in;
  logic        flush;
  logic        addr_error_out;
  logic [31:0] bad_addr_out;
  logic        ram_write_en;
  logic [31:0] ram_addr;
  logic [3:0]  ram_write_sel;
  logic [31:0] ram_write_data;
  logic        ram_write_ack;
  logic [31:0] load_addr_in;
  logic        load_conflict_out;
  logic        buffer_empty_out;

  modport master (
    output store_valid_in, store_addr_in, store_data_in,
    output mem_sel_in, flush, ram_write_ack, load_addr_in,
    input  store_ready_out, addr_error_out, bad_addr_out,
    input  ram_write_en, ram_addr, ram_write_sel, ram_write_data,
    input  load_conflict_out, buffer_empty_out
  );

  modport slave (
    input  store_valid_in, store_addr_in, store_data_in,
    input  mem_sel_in, flush, ram_write_ack, load_addr_in,
    output store_ready_out, addr_error_out, bad_addr_out,
    output ram_write_en, ram_addr, ram_write_sel, ram_write_data,
    output load_conflict_out, buffer_empty_out
  );
endinterface

// File: rtl/mem_store_unit.sv
// Store lane alignment plus a small store buffer draining to RAM.
// Misaligned/illegal stores are rejected with an address error pulse.
module mem_store_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic            clk,
  input logic            rst,
  mem_store_unit_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [29:0]      e_addr [DEPTH];
  logic [3:0]       e_sel  [DEPTH];
  logic [31:0]      e_data [DEPTH];
  logic [DEPTH-1:0] e_vld;

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  logic [1:0]  a;
  logic        aligned;
  logic [3:0]  st_sel;
  logic [31:0] st_data;
  logic        push;
  logic        pop;
  logic        reject;
  logic        err_q;
  logic [31:0] bad_q;
  logic        conflict;
  logic        unused_load_lsb;

  assign a = bus.store_addr_in[1:0];
  assign unused_load_lsb = ^bus.load_addr_in[1:0];

  // Size decode: lane select, replicated data, alignment legality
  always_comb begin
    aligned = 1'b0;
    st_sel  = 4'b0000;
    st_data = '0;
    unique case (bus.mem_sel_in)
      4'b0001: begin
        aligned = 1'b1;
        st_sel  = 4'b0001 << a;
        st_data = {4{bus.store_data_in[7:0]}};
      end
      4'b0011: begin
        aligned = ~a[0];
        st_sel  = a[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.store_data_in[15:0]}};
      end
      4'b1111: begin
        aligned = (a == 2'b00);
        st_sel  = 4'b1111;
        st_data = bus.store_data_in;
      end
      default: aligned = 1'b0;
    endcase
  end

  assign bus.store_ready_out = (count_q != FULL_CNT);
  assign push = bus.store_valid_in & bus.store_ready_out
              & ~bus.flush & aligned;
  assign pop  = (count_q != '0) & bus.ram_write_ack;
  assign reject = bus.store_valid_in & ~bus.flush & ~aligned;

  // Head/tail pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push && !pop)
        count_q <= count_q + (PTR_W+1)'(1);
      else if (pop && !push)
        count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Entry storage: write at tail, invalidate at head on ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_sel[i]  <= '0;
        e_data[i] <= '0;
      end
    end else begin
      if (pop) e_vld[head_q] <= 1'b0;
      if (push) begin
        e_vld[tail_q]  <= 1'b1;
        e_addr[tail_q] <= bus.store_addr_in[31:2];
        e_sel[tail_q]  <= st_sel;
        e_data[tail_q] <= st_data;
      end
    end
  end

  // Error pulse and sticky faulting address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
      bad_q <= '0;
    end else begin
      err_q <= reject;
      if (reject) bad_q <= bus.store_addr_in;
    end
  end

  // Loads hitting any pending word must stall
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (e_vld[i] && e_addr[i] == bus.load_addr_in[31:2])
        conflict = 1'b1;
  end

  assign bus.ram_write_en = (count_q != '0);
  assign bus.ram_addr = bus.ram_write_en
    ? {e_addr[head_q], 2'b00} : '0;
  assign bus.ram_write_sel = bus.ram_write_en
    ? e_sel[head_q] : '0;
  assign bus.ram_write_data = bus.ram_write_en
    ? e_data[head_q] : '0;
  assign bus.addr_error_out    = err_q;
  assign bus.bad_addr_out      = bad_q;
  assign bus.load_conflict_out = conflict;
  assign bus.buffer_empty_out  = (count_q == '0);

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: queue model, per-cycle compare,
// directed scenarios with literal pins, then random traffic.
module tb_mem_store_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;

  mem_store_unit_if bus();

  mem_store_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_err = 1'b0;
  logic [31:0] m_bad = '0;
  bit          m_ok;
  logic [3:0]  m_sel;
  logic [31:0] m_data;
  int          m_n0;
  logic        m_conf;
  ent_t        m_head;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Size code -> number of bytes; lane b takes byte (b mod n)
  function automatic void align(input logic [31:0] ad,
                                input logic [3:0] code,
                                input logic [31:0] d,
                                output bit ok,
                                output logic [3:0] sel,
                                output logic [31:0] data);
    int n;
    int off;
    n = (code == 4'h1) ? 1 : (code == 4'h3) ? 2 :
        (code == 4'hF) ? 4 : 0;
    off = int'(ad[1:0]);
    sel = '0;
    data = '0;
    ok = (n != 0) && (off % n == 0);
    if (n != 0) begin
      sel = 4'(((1 << n) - 1) << off);
      for (int b = 0; b < 4; b++)
        data[8*b +: 8] = d[8*(b % n) +: 8];
    end
  endfunction

  // Reference model state update
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_err = 1'b0;
      m_bad = '0;
    end else begin
      m_n0 = q.size();
      align(bus.store_addr_in, bus.mem_sel_in, bus.store_data_in,
            m_ok, m_sel, m_data);
      m_err = bus.store_valid_in && !bus.flush && !m_ok;
      if (m_err) m_bad = bus.store_addr_in;
      if (m_n0 != 0 && bus.ram_write_ack) void'(q.pop_front());
      if (bus.store_valid_in && !bus.flush && m_ok && m_n0 < DEPTH)
        q.push_back('{{bus.store_addr_in[31:2], 2'b00},
                      m_sel, m_data});
    end
  end

  // Compare every output against the model each cycle
  always @(negedge clk) begin
    m_conf = 1'b0;
    foreach (q[i])
      if (q[i].addr[31:2] == bus.load_addr_in[31:2]) m_conf = 1'b1;
    if (q.size() != 0) m_head = q[0];
    else m_head = '{32'h0, 4'h0, 32'h0};
    chk("ready", 32'(bus.store_ready_out), 32'(q.size() < DEPTH));
    chk("wr_en", 32'(bus.ram_write_en), 32'(q.size() != 0));
    chk("ram_addr", bus.ram_addr, m_head.addr);
    chk("ram_sel", 32'(bus.ram_write_sel), 32'(m_head.sel));
    chk("ram_data", bus.ram_write_data, m_head.data);
    chk("conflict", 32'(bus.load_conflict_out), 32'(m_conf));
    chk("empty", 32'(bus.buffer_empty_out), 32'(q.size() == 0));
    chk("addr_err", 32'(bus.addr_error_out), 32'(m_err));
    chk("bad_addr", bus.bad_addr_out, m_bad);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [31:0] ad, logic [3:0] code,
                     logic [31:0] d);
    bus.store_valid_in = 1'b1;
    bus.store_addr_in  = ad;
    bus.mem_sel_in     = code;
    bus.store_data_in  = d;
  endtask

  task automatic drain();
    bus.store_valid_in = 1'b0;
    bus.ram_write_ack  = 1'b1;
    for (int k = 0; k < 20 && !bus.buffer_empty_out; k++) tick();
    chk("drain_done", 32'(bus.buffer_empty_out), 32'd1);
    bus.ram_write_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.store_valid_in = 1'b0;
    bus.store_addr_in  = '0;
    bus.store_data_in  = '0;
    bus.mem_sel_in     = '0;
    bus.flush          = 1'b0;
    bus.ram_write_ack  = 1'b0;
    bus.load_addr_in   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.store_ready_out), 32'd1);
    chk("rst_empty", 32'(bus.buffer_empty_out), 32'd1);
    chk("rst_wren", 32'(bus.ram_write_en), 32'd0);
    #2 rst = 1'b1;
    tick();

    // Byte lanes, back-to-back writes
    bus.ram_write_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(32'h1000 + 32'(i), 4'h1, 32'h0000_00A5);
      tick();
      @(negedge clk);
      chk("byte_sel", 32'(bus.ram_write_sel), 32'(1 << i));
      chk("byte_data", bus.ram_write_data, 32'hA5A5_A5A5);
      chk("byte_addr", bus.ram_addr, 32'h1000);
    end
    drain();

    // Upper half, then a misaligned word
    put(32'h2002, 4'h3, 32'h1234_BEEF);
    tick();
    @(negedge clk);
    chk("half_sel", 32'(bus.ram_write_sel), 32'hC);
    chk("half_data", bus.ram_write_data, 32'hBEEF_BEEF);
    put(32'h2001, 4'hF, 32'h5555_AAAA);
    tick();
    @(negedge clk);
    chk("mis_err", 32'(bus.addr_error_out), 32'd1);
    chk("mis_bad", bus.bad_addr_out, 32'h2001);
    chk("mis_head", bus.ram_addr, 32'h2000);
    bus.store_valid_in = 1'b0;
    tick();
    @(negedge clk);
    chk("mis_pulse", 32'(bus.addr_error_out), 32'd0);
    drain();

    // Fill, refuse fifth, ack, wrap
    for (int i = 0; i < 4; i++) begin
      put(32'h3000 + 32'(4 * i), 4'hF, 32'h3000_0000 + 32'(i));
      tick();
    end
    @(negedge clk);
    chk("full_ready", 32'(bus.store_ready_out), 32'd0);
    put(32'h3010, 4'hF, 32'h3000_0004);
    tick();
    @(negedge clk);
    chk("full_head", bus.ram_addr, 32'h3000);
    bus.ram_write_ack = 1'b1;
    tick();
    @(negedge clk);
    chk("ack_ready", 32'(bus.store_ready_out), 32'd1);
    chk("ack_head", bus.ram_addr, 32'h3004);
    tick();
    drain();

    // Load conflict on pending word
    put(32'h4008, 4'hF, 32'h4444_4444);
    tick();
    bus.store_valid_in = 1'b0;
    bus.load_addr_in = 32'h400B;
    @(negedge clk);
    chk("conf_hit", 32'(bus.load_conflict_out), 32'd1);
    bus.load_addr_in = 32'h400C;
    #1;
    chk("conf_miss", 32'(bus.load_conflict_out), 32'd0);
    bus.load_addr_in = 32'h4008;
    bus.ram_write_ack = 1'b1;
    tick();
    @(negedge clk);
    chk("conf_pop", 32'(bus.load_conflict_out), 32'd0);
    bus.ram_write_ack = 1'b0;

    // Flush hides misalignment; illegal size errors
    bus.flush = 1'b1;
    put(32'h5001, 4'h3, 32'h0);
    tick();
    @(negedge clk);
    chk("flush_err", 32'(bus.addr_error_out), 32'd0);
    chk("flush_empty", 32'(bus.buffer_empty_out), 32'd1);
    bus.flush = 1'b0;
    put(32'h5000, 4'h7, 32'h0);
    tick();
    @(negedge clk);
    chk("ill_err", 32'(bus.addr_error_out), 32'd1);
    chk("ill_bad", bus.bad_addr_out, 32'h5000);
    chk("ill_empty", 32'(bus.buffer_empty_out), 32'd1);
    bus.store_valid_in = 1'b0;
    tick();

    // Asynchronous reset with writes pending
    put(32'h6000, 4'hF, 32'h6);
    tick();
    put(32'h6004, 4'hF, 32'h7);
    tick();
    bus.store_valid_in = 1'b0;
    @(negedge clk);
    chk("pre_rst_en", 32'(bus.ram_write_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_en", 32'(bus.ram_write_en), 32'd0);
    chk("arst_empty", 32'(bus.buffer_empty_out), 32'd1);
    chk("arst_err", 32'(bus.addr_error_out), 32'd0);
    bus.ram_write_ack = 1'b1;
    tick();
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    put(32'h7000, 4'hF, 32'hCAFE_F00D);
    tick();
    bus.store_valid_in = 1'b0;
    @(negedge clk);
    chk("post_addr", bus.ram_addr, 32'h7000);
    chk("post_data", bus.ram_write_data, 32'hCAFE_F00D);
    tick();
    @(negedge clk);
    chk("post_empty", 32'(bus.buffer_empty_out), 32'd1);
    bus.ram_write_ack = 1'b0;
    tick();

    // Random traffic in a small address window
    for (int c = 0; c < 400; c++) begin
      bus.store_valid_in = ($urandom % 4) != 0;
      bus.store_addr_in  = 32'h8000 + 32'($urandom_range(0, 31));
      bus.store_data_in  = $urandom;
      case ($urandom % 8)
        0, 1, 2: bus.mem_sel_in = 4'h1;
        3, 4:    bus.mem_sel_in = 4'h3;
        5, 6:    bus.mem_sel_in = 4'hF;
        default: bus.mem_sel_in = 4'($urandom);
      endcase
      bus.flush         = ($urandom % 10) == 0;
      bus.ram_write_ack = ($urandom % 3) != 0;
      bus.load_addr_in  = 32'h8000 + 32'($urandom_range(0, 31));
      tick();
    end
    bus.flush = 1'b0;
    drain();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
- Write-side counterpart of the load-data extraction in the writeback path.
- Accepts store requests from the MEM stage and aligns byte, half-word and word data into 32-bit RAM write lanes with a per-byte write select.
- Detects misaligned or illegal store sizes and reports them as address errors.
- Queues accepted stores in a small FIFO that drains to the RAM write port over a req/ack handshake. It exports a load-conflict flag so the pipeline can stall loads that hit a pending store.

Parameters:
DEPTH, 4, store buffer entries; power of two, >= 2
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-low (0 = reset)
store_valid_in  input  1  MEM stage presents a store this cycle
store_ready_out  output  1  buffer can accept a store (count < DEPTH)
store_addr_in  input  32  byte address of store
store_data_in  input  32  register value; low byte/half/word is stored
mem_sel_in  input  4  size code: 4'b0001 byte, 4'b0011 half, 4'b1111 word
flush  input  1  exception flush; the incoming store this cycle is discarded
addr_error_out  output  1  one-cycle pulse: rejected store
bad_addr_out  output  32  address of most recent rejected store
ram_write_en  output  1  head entry valid, write requested
ram_addr  output  32  word address of head entry, bits [1:0] = 2'b00
ram_write_sel  output  4  byte lane enables of head entry
ram_write_data  output  32  lane-replicated data of head entry
ram_write_ack  input  1  RAM accepted current write
load_addr_in  input  32  address of load in MEM stage
load_conflict_out  output  1  a pending entry shares load_addr_in[31:2]
buffer_empty_out  output  1  count == 0

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count go to 0; all entries are invalid.
  - store_ready_out=1, ram_write_en=0, ram_addr/ram_write_sel/ram_write_data=0.
  - addr_error_out=0, bad_addr_out=0, load_conflict_out=0, buffer_empty_out=1.
  - Reset mid-handshake drops all pending stores; no write completes after reset.
- Accept condition: store_valid_in & store_ready_out & ~flush & aligned.
  - Accepted stores are written at the tail; tail and count update on the next edge.
- Alignment, a = store_addr_in[1:0]:
  - byte (0001): sel = 4'b0001 << a; data = {4{store_data_in[7:0]}}; always aligned.
  - half (0011): a=00 -> sel 0011; a=10 -> sel 1100; data = {2{store_data_in[15:0]}}; a odd -> misaligned.
  - word (1111): a=00 -> sel 1111, data = store_data_in; any other a -> misaligned.
  - Any other mem_sel_in value is illegal and treated as misaligned.
- Rejection: store_valid_in & ~flush & misaligned, regardless of store_ready_out.
  - Nothing is enqueued.
  - Next edge: addr_error_out=1 for exactly one cycle; bad_addr_out=store_addr_in, held until the next rejection.
  - flush suppresses both enqueue and error.
- Entry contents: {addr[31:2], sel, data}. Stored ram_addr = {addr[31:2], 2'b00}.
- Drain:
  - ram_write_en = (count != 0); ram_addr/sel/data come from the head entry and are registered-state driven, with no combinational path from store_* inputs.
  - The head is held stable while ram_write_en=1 and ram_write_ack=0.
  - On an edge with ram_write_en & ram_write_ack, head advances and count decrements. The next entry is presented in the following cycle, giving back-to-back writes.
  - ram_write_ack while count==0 is ignored.
  - When count==0, ram_addr/sel/data are driven to 0.
- Simultaneous push and pop (count not full): count is unchanged, both pointers advance.
- Full (count==DEPTH): store_ready_out=0 even if an ack arrives that cycle (no push-through). The store must be re-presented next cycle.
- Pointers wrap modulo DEPTH. count is PTR_W+1 bits and ranges 0..DEPTH.
- load_conflict_out is combinational: OR over valid entries of (entry addr[31:2] == load_addr_in[31:2]). It includes the head during an ack cycle and excludes a store being accepted that same cycle.
- buffer_empty_out = (count == 0).

Test Plan:
- Byte stores: addr 0x1000..0x1003, data 0x000000A5, ack held 1 -> ram_write_sel 0001, 0010, 0100, 1000 with ram_write_data 0xA5A5A5A5 and ram_addr 0x1000 each, one write per cycle.
- Half at 0x2002, data 0x1234BEEF -> sel 1100, data 0xBEEFBEEF. Word at 0x2001 -> no enqueue, addr_error_out pulses 1 cycle, bad_addr_out=0x2001.
- Fill/stall: ack=0, push 4 words to 0x3000, 0x3004, 0x3008, 0x300C -> store_ready_out=0 after the 4th. A 5th store is refused. Ack the next cycle -> the 0x3000 write completes, ready returns 1 the following cycle, FIFO order is preserved after wrap.
- Load conflict: pending word store at 0x4008; load_addr_in=0x400B -> load_conflict_out=1; load_addr_in=0x400C -> 0. After the ack pops the entry -> 0.
- Flush plus misalignment: flush=1 with a misaligned half at 0x5001 -> no error pulse, no enqueue. An illegal mem_sel 0x7 at 0x5000 without flush -> error pulse.
- Reset mid-write: 2 entries pending, ram_write_en=1, assert rst=0 asynchronously -> ram_write_en=0 immediately, buffer_empty_out=1. After release, a new store drains normally.
